weight_buffer_pingpong: RTL and testbench

Double-banked weight buffer that sits directly upstream of the west-side weight scheduler.
- Write side: accepts a serial valid/ready stream of INT_WIDTH weights from the loader/DMA and fills the idle bank.
- Read side: the scheduler reads the active bank with 1-cycle synchronous latency, K_CHANNELS lanes per address.
- A swap handshake lets the next layer's weights load while the current layer computes.

---
 rtl/weight_buffer_pingpong_pkg.sv | 16 +
 rtl/weight_buffer_pingpong_ram.sv | 32 +++
 rtl/weight_buffer_pingpong.sv | 168 ++++++++++++++++
 tb/tb_weight_buffer_pingpong.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_pingpong_pkg.sv
// Shared sizing constants and FSM state type for the ping-pong weight buffer.
package weight_buffer_pingpong_pkg;

    localparam int K_CHANNELS  = 8;
    localparam int INT_WIDTH   = 8;
    localparam int SRAM_ADDR_W = 4;
    localparam int WB_DEPTH    = 16;
    localparam int CH_W        = $clog2(K_CHANNELS);
    localparam int LANES_W     = K_CHANNELS * INT_WIDTH;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/weight_buffer_pingpong_ram.sv
// One weight bank: WB_DEPTH words of K_CHANNELS lanes, per-lane write enable,
// registered read port. Storage carries no reset; the top gates unread data.
module wb_bank_ram
    import weight_buffer_pingpong_pkg::*;
(
    input  logic                   clk,
    input  logic                   we,
    input  logic [SRAM_ADDR_W-1:0] waddr,
    input  logic [K_CHANNELS-1:0]  wlane,
    input  logic [INT_WIDTH-1:0]   wdata,
    input  logic                   re,
    input  logic [SRAM_ADDR_W-1:0] raddr,
    output logic [LANES_W-1:0]     rdata
);

    logic [LANES_W-1:0] mem [WB_DEPTH];

    // Lane-selective write and synchronous read; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < K_CHANNELS; c++) begin
                if (wlane[c]) begin
                    mem[waddr][c*INT_WIDTH +: INT_WIDTH] <= wdata;
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_buffer_pingpong.sv
// Double-banked weight buffer: a serial stream fills the idle bank while the
// scheduler reads the active bank; a swap handshake exchanges their roles.
module weight_buffer_pingpong
    import weight_buffer_pingpong_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_async_n_i,
    input  logic [3:0]             cfg_kernel_r_i,
    input  logic                   load_start_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [INT_WIDTH-1:0]   s_data_i,
    output logic                   load_busy_o,
    output logic                   load_done_o,
    output logic                   cfg_err_o,
    input  logic                   swap_i,
    output logic                   rd_bank_o,
    output logic                   rd_bank_valid_o,
    output logic [1:0]             bank_full_o,
    input  logic                   wb_rd_en_i,
    input  logic [SRAM_ADDR_W-1:0] wb_addr_i,
    output logic [LANES_W-1:0]     wb_data_o
);

    wb_state_e              state;
    logic                   rd_bank;
    logic [1:0]             bank_full;
    logic [7:0]             size [2];
    logic [CH_W-1:0]        ch_cnt;
    logic [SRAM_ADDR_W-1:0] addr_cnt;
    logic                   load_done;
    logic                   cfg_err;
    logic                   rd_ok;
    logic                   rd_sel;

    logic                   fill;
    logic                   swap_ok;
    logic                   rd_bank_next;
    logic [1:0]             full_swapped;
    logic                   tgt;
    logic [7:0]             r_sq;
    logic                   start_req;
    logic                   start_ok;
    logic                   beat;
    logic                   last_beat;
    logic                   rd_in_range;
    logic [K_CHANNELS-1:0]  lane_en;
    logic [LANES_W-1:0]     rdata [2];

    // Fill bank is always the one not being read; loads never touch rd_bank.
    assign fill         = ~rd_bank;
    assign swap_ok      = (state == WB_IDLE) && swap_i && bank_full[fill];
    assign rd_bank_next = swap_ok ? fill : rd_bank;
    assign tgt          = ~rd_bank_next;
    assign r_sq         = {4'd0, cfg_kernel_r_i} * {4'd0, cfg_kernel_r_i};
    assign start_req    = (state == WB_IDLE) && load_start_i;
    assign start_ok     = start_req && !full_swapped[tgt] &&
                          (cfg_kernel_r_i != 4'd0) && (r_sq <= 8'(WB_DEPTH));
    assign beat         = (state == WB_LOAD) && s_valid_i;
    assign last_beat    = beat && (ch_cnt == CH_W'(K_CHANNELS - 1)) &&
                          (8'(addr_cnt) == size[fill] - 8'd1);
    assign rd_in_range  = bank_full[rd_bank] && (8'(wb_addr_i) < size[rd_bank]);

    // Full flags as seen after a swap in this cycle, so a same-cycle start
    // evaluates the bank that the swap just released.
    always_comb begin
        full_swapped = bank_full;
        if (swap_ok) begin
            full_swapped[rd_bank] = 1'b0;
        end
    end

    // One-hot lane enable for the channel currently being streamed.
    always_comb begin
        lane_en         = '0;
        lane_en[ch_cnt] = 1'b1;
    end

    // Load FSM and address-major / channel-fastest beat counters.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state    <= WB_IDLE;
            ch_cnt   <= '0;
            addr_cnt <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (start_ok) begin
                        state    <= WB_LOAD;
                        ch_cnt   <= '0;
                        addr_cnt <= '0;
                    end
                end
                default: begin
                    if (beat) begin
                        if (last_beat) begin
                            state <= WB_IDLE;
                        end
                        if (ch_cnt == CH_W'(K_CHANNELS - 1)) begin
                            ch_cnt   <= '0;
                            addr_cnt <= addr_cnt + SRAM_ADDR_W'(1);
                        end else begin
                            ch_cnt <= ch_cnt + CH_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Bank roles, full flags, per-bank sizes and the one-cycle status pulses.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            size[0]   <= '0;
            size[1]   <= '0;
            load_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            rd_bank   <= rd_bank_next;
            bank_full <= full_swapped;
            if (last_beat) begin
                bank_full[fill] <= 1'b1;
            end
            if (start_ok) begin
                size[tgt] <= r_sq;
            end
            load_done <= last_beat;
            cfg_err   <= start_req && !start_ok;
        end
    end

    // Read-side qualifiers captured with the read; they pick the bank and
    // zero-gate the RAM output, and hold along with it when no read is issued.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            rd_ok  <= 1'b0;
            rd_sel <= 1'b0;
        end else if (wb_rd_en_i) begin
            rd_ok  <= rd_in_range;
            rd_sel <= rd_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wb_bank_ram u_ram (
            .clk   (clk_i),
            .we    (beat && (fill == 1'(b))),
            .waddr (addr_cnt),
            .wlane (lane_en),
            .wdata (s_data_i),
            .re    (wb_rd_en_i),
            .raddr (wb_addr_i),
            .rdata (rdata[b])
        );
    end

    assign wb_data_o       = rd_ok ? rdata[rd_sel] : '0;
    assign s_ready_o       = (state == WB_LOAD);
    assign load_busy_o     = (state == WB_LOAD);
    assign load_done_o     = load_done;
    assign cfg_err_o       = cfg_err;
    assign rd_bank_o       = rd_bank;
    assign rd_bank_valid_o = bank_full[rd_bank];
    assign bank_full_o     = bank_full;

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// Scoreboard bench for weight_buffer_pingpong: reads push expected words,
// a monitor pops and compares when the registered read data appears.
module tb_weight_buffer_pingpong;
    import weight_buffer_pingpong_pkg::*;

    localparam int DW = LANES_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [3:0]             cfg_r = '0;
    logic                   load_start = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [INT_WIDTH-1:0]   s_data = '0;
    logic                   load_busy;
    logic                   load_done;
    logic                   cfg_err;
    logic                   swap = 1'b0;
    logic                   rd_bank;
    logic                   rd_bank_valid;
    logic [1:0]             bank_full;
    logic                   rd_en = 1'b0;
    logic [SRAM_ADDR_W-1:0] rd_addr = '0;
    logic [DW-1:0]          rd_data;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    weight_buffer_pingpong dut (
        .clk_i           (clk),
        .rst_async_n_i   (rst_n),
        .cfg_kernel_r_i  (cfg_r),
        .load_start_i    (load_start),
        .s_valid_i       (s_valid),
        .s_ready_o       (s_ready),
        .s_data_i        (s_data),
        .load_busy_o     (load_busy),
        .load_done_o     (load_done),
        .cfg_err_o       (cfg_err),
        .swap_i          (swap),
        .rd_bank_o       (rd_bank),
        .rd_bank_valid_o (rd_bank_valid),
        .bank_full_o     (bank_full),
        .wb_rd_en_i      (rd_en),
        .wb_addr_i       (rd_addr),
        .wb_data_o       (rd_data)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Lane c of the word holds base + c.
    function automatic logic [DW-1:0] seq(input int base);
        logic [DW-1:0] v;
        for (int c = 0; c < K_CHANNELS; c++) v[c*INT_WIDTH +: INT_WIDTH] = INT_WIDTH'(base + c);
        return v;
    endfunction

    // Monitor: counts accepted beats and checks read data one edge after a read.
    initial begin
        logic mon_rd;
        forever begin
            @(posedge clk);
            mon_rd = rst_n && rd_en;
            if (rst_n && s_valid && s_ready) acc_cnt++;
            #1;
            if (mon_rd) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got %h, expected no read", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_load(input logic [3:0] r, input logic sw);
        cfg_r = r;
        load_start = 1'b1;
        swap = sw;
        @(negedge clk);
        load_start = 1'b0;
        swap = 1'b0;
    endtask

    task automatic stream(input int n, input int base);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            s_valid = 1'b1;
            s_data = INT_WIDTH'(base + b);
            @(posedge clk);
            if (!s_ready) ok = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("stream_ready", DW'(ok), DW'(1));
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp, input logic sw);
        rd_en = 1'b1;
        rd_addr = SRAM_ADDR_W'(addr);
        swap = sw;
        exp_q.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
        swap = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
    endtask

    initial begin
        int base;
        cyc(2);
        chk("rst_ready", DW'(s_ready), DW'(0));
        chk("rst_busy", DW'(load_busy), DW'(0));
        chk("rst_done", DW'(load_done), DW'(0));
        chk("rst_err", DW'(cfg_err), DW'(0));
        chk("rst_full", DW'(bank_full), DW'(0));
        chk("rst_rd_bank", DW'(rd_bank), DW'(0));
        chk("rst_rd_valid", DW'(rd_bank_valid), DW'(0));
        chk("rst_data", rd_data, '0);
        rst_n = 1'b1;
        cyc(1);

        // Basic load R=3 into bank 1, then swap
        start_load(4'd3, 1'b0);
        chk("s1_busy", DW'(load_busy), DW'(1));
        chk("s1_ready", DW'(s_ready), DW'(1));
        stream(72, 0);
        chk("s1_done", DW'(load_done), DW'(1));
        chk("s1_full", DW'(bank_full), DW'(2'b10));
        chk("s1_ready_drop", DW'(s_ready), DW'(0));
        chk("s1_rd_valid_pre", DW'(rd_bank_valid), DW'(0));
        cyc(1);
        chk("s1_done_once", DW'(load_done), DW'(0));
        rd(0, '0, 1'b0);
        do_swap();
        chk("s1_rd_bank", DW'(rd_bank), DW'(1));
        chk("s1_rd_valid", DW'(rd_bank_valid), DW'(1));
        chk("s1_full_post", DW'(bank_full), DW'(2'b10));
        rd(4, seq(32), 1'b0);
        rd(8, seq(64), 1'b0);
        rd(9, '0, 1'b0);

        // Ping-pong: load R=2 into bank 0 while bank 1 is read
        start_load(4'd2, 1'b0);
        chk("s2_busy", DW'(load_busy), DW'(1));
        stream(16, 100);
        rd(2, seq(16), 1'b1);
        chk("s2_swap_in_load", DW'(rd_bank), DW'(1));
        stream(16, 116);
        chk("s2_done", DW'(load_done), DW'(1));
        chk("s2_full", DW'(bank_full), DW'(2'b11));
        rd(3, seq(24), 1'b1);
        chk("s2_rd_bank", DW'(rd_bank), DW'(0));
        chk("s2_full_post", DW'(bank_full), DW'(2'b01));
        rd(3, seq(124), 1'b0);

        // Rejected starts
        start_load(4'd0, 1'b0);
        chk("s4_err_r0", DW'(cfg_err), DW'(1));
        chk("s4_ready_r0", DW'(s_ready), DW'(0));
        start_load(4'd5, 1'b0);
        chk("s4_err_r5", DW'(cfg_err), DW'(1));
        chk("s4_busy_r5", DW'(load_busy), DW'(0));
        cyc(1);
        chk("s4_err_clear", DW'(cfg_err), DW'(0));

        // Stalling stream, R=1 into bank 1
        start_load(4'd1, 1'b0);
        chk("s3_busy", DW'(load_busy), DW'(1));
        base = acc_cnt;
        for (int i = 0; i < 16; i++) begin
            s_valid = (i % 2 == 0);
            s_data = INT_WIDTH'(200 + i / 2);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data = INT_WIDTH'(250);
        cyc(4);
        s_valid = 1'b0;
        chk("s3_beats", DW'(acc_cnt - base), DW'(8));
        chk("s3_ready", DW'(s_ready), DW'(0));
        chk("s3_full", DW'(bank_full), DW'(2'b11));
        start_load(4'd2, 1'b0);
        chk("s4_err_full", DW'(cfg_err), DW'(1));

        // Simultaneous swap and start loads the bank just released
        start_load(4'd2, 1'b1);
        chk("s5_rd_bank", DW'(rd_bank), DW'(1));
        chk("s5_busy", DW'(load_busy), DW'(1));
        chk("s5_full", DW'(bank_full), DW'(2'b10));
        rd(0, seq(200), 1'b0);
        rd(1, '0, 1'b0);
        stream(32, 50);
        do_swap();
        chk("s5_rd_bank_back", DW'(rd_bank), DW'(0));
        rd(1, seq(58), 1'b0);

        // Asynchronous reset in the middle of a load
        start_load(4'd3, 1'b0);
        stream(40, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_full", DW'(bank_full), DW'(0));
        chk("s6_ready", DW'(s_ready), DW'(0));
        chk("s6_data", rd_data, '0);
        chk("s6_busy", DW'(load_busy), DW'(0));
        @(negedge clk);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        start_load(4'd3, 1'b0);
        chk("s6_busy_new", DW'(load_busy), DW'(1));
        stream(72, 0);
        chk("s6_done", DW'(load_done), DW'(1));
        do_swap();
        chk("s6_rd_bank", DW'(rd_bank), DW'(1));
        rd(8, seq(64), 1'b0);
        rd(0, seq(0), 1'b0);

        cyc(3);
        chk("sb_drain", DW'(exp_q.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
